cdb_arbiter: RTL and testbench

- Parametrised multi-lane common data bus arbiter: successor to the single-lane, fixed-priority CDB selector.
- Accepts completed results from NUM_REQ functional units and grants up to NUM_CDB of them per cycle.
- Arbitration is round-robin, with mispredicted branches promoted; a fixed-priority legacy mode is selectable.
- Sits between the execute stage and ROB/RS wakeup. Granted results are registered and broadcast on the next cycle.

---
 rtl/cdb_arbiter_if.sv | 37 +++
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the CDB arbiter.
// The arbiter takes the slave view; the execute-side driver takes the master view.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LOC_W   = 32
);
  localparam int unsigned CNT_W = $clog2(NUM_CDB + 1);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_value;
  logic [NUM_REQ-1:0]        req_mispred;
  logic [NUM_REQ*LOC_W-1:0]  req_loc;
  logic [NUM_REQ-1:0]        req_ready;

  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_value;
  logic [NUM_CDB-1:0]        cdb_mispred;
  logic [NUM_CDB*LOC_W-1:0]  cdb_loc;
  logic [CNT_W-1:0]          cdb_count;

  modport master (
    output req_valid, req_tag, req_value, req_mispred, req_loc,
    input  req_ready,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispred, cdb_loc, cdb_count
  );

  modport slave (
    input  req_valid, req_tag, req_value, req_mispred, req_loc,
    output req_ready,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispred, cdb_loc, cdb_count
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Multi-lane common data bus arbiter: round-robin with mispredict promotion
// (or fixed highest-index priority), grants registered and broadcast next cycle.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LOC_W   = 32,
  parameter bit          RR_MODE = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  cdb_arbiter_if.slave               bus,
  output logic [$clog2(NUM_REQ)-1:0] rr_ptr_dbg
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(NUM_CDB + 1);

  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          ptr_nxt;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_CDB-1:0]        lane_valid;
  logic [PTR_W-1:0]          lane_idx [NUM_CDB];
  logic [NUM_CDB*TAG_W-1:0]  nxt_tag;
  logic [NUM_CDB*DATA_W-1:0] nxt_value;
  logic [NUM_CDB-1:0]        nxt_mispred;
  logic [NUM_CDB*LOC_W-1:0]  nxt_loc;
  logic [CNT_W-1:0]          count;

  // Selection: the k-th grant in search order lands on lane k. In round-robin
  // mode pass 0 takes mispredicts and pass 1 the rest; the pointer follows the
  // last grant, which is the last pass-1 grant whenever one exists.
  always_comb begin : select
    int unsigned n;
    int unsigned last;
    int unsigned idx;
    logic [PTR_W-1:0] sel;
    grant      = '0;
    lane_valid = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) lane_idx[k] = '0;
    n    = 0;
    last = 32'(rr_ptr);
    idx  = 0;
    sel  = '0;
    if (RR_MODE) begin
      for (int unsigned pass = 0; pass < 2; pass++) begin
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
          idx = 32'(rr_ptr) + j;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          sel = PTR_W'(idx);
          if (n < NUM_CDB && bus.req_valid[sel] &&
              (bus.req_mispred[sel] == (pass == 0))) begin
            grant[sel] = 1'b1;
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
              if (k == n) begin
                lane_valid[k] = 1'b1;
                lane_idx[k]   = sel;
              end
            end
            n    = n + 1;
            last = idx;
          end
        end
      end
    end else begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        idx = NUM_REQ - 1 - j;
        sel = PTR_W'(idx);
        if (n < NUM_CDB && bus.req_valid[sel]) begin
          grant[sel] = 1'b1;
          for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (k == n) begin
              lane_valid[k] = 1'b1;
              lane_idx[k]   = sel;
            end
          end
          n = n + 1;
        end
      end
    end
    if (last + 1 >= NUM_REQ) ptr_nxt = '0;
    else                     ptr_nxt = PTR_W'(last + 1);
  end

  // Ready is gated by reset and flush only, never by the broadcast registers.
  assign bus.req_ready = (reset && !flush) ? grant : '0;

  always_comb begin : lane_mux
    nxt_tag     = '0;
    nxt_value   = '0;
    nxt_mispred = '0;
    nxt_loc     = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (lane_valid[k] && lane_idx[k] == PTR_W'(i)) begin
          nxt_tag[k*TAG_W +: TAG_W]    = bus.req_tag[i*TAG_W +: TAG_W];
          nxt_value[k*DATA_W +: DATA_W] = bus.req_value[i*DATA_W +: DATA_W];
          nxt_mispred[k]               = bus.req_mispred[i];
          nxt_loc[k*LOC_W +: LOC_W]    = bus.req_loc[i*LOC_W +: LOC_W];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.cdb_valid   <= '0;
      bus.cdb_tag     <= '0;
      bus.cdb_value   <= '0;
      bus.cdb_mispred <= '0;
      bus.cdb_loc     <= '0;
      rr_ptr          <= '0;
    end else if (flush) begin
      bus.cdb_valid <= '0;
    end else begin
      bus.cdb_valid   <= lane_valid;
      bus.cdb_tag     <= nxt_tag;
      bus.cdb_value   <= nxt_value;
      bus.cdb_mispred <= nxt_mispred;
      bus.cdb_loc     <= nxt_loc;
      if (RR_MODE && |lane_valid) rr_ptr <= ptr_nxt;
    end
  end

  always_comb begin : popcount
    count = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) count = count + CNT_W'(bus.cdb_valid[k]);
  end

  assign bus.cdb_count = count;
  assign rr_ptr_dbg    = rr_ptr;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: three configurations (8x2 RR, 4x2 RR, 4x1 fixed).
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fl8 = 1'b0, fl4 = 1'b0, fl1 = 1'b0;
  logic [2:0] ptr8;
  logic [1:0] ptr4;
  logic [1:0] ptr1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(8), .NUM_CDB(2), .TAG_W(5), .DATA_W(32), .LOC_W(32)) b8();
  cdb_arbiter_if #(.NUM_REQ(4), .NUM_CDB(2), .TAG_W(5), .DATA_W(32), .LOC_W(32)) b4();
  cdb_arbiter_if #(.NUM_REQ(4), .NUM_CDB(1), .TAG_W(5), .DATA_W(32), .LOC_W(32)) b1();

  cdb_arbiter #(.NUM_REQ(8), .NUM_CDB(2), .TAG_W(5), .DATA_W(32), .LOC_W(32), .RR_MODE(1'b1))
    u_def (.clock(clk), .reset(rst_n), .flush(fl8), .bus(b8), .rr_ptr_dbg(ptr8));
  cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(2), .TAG_W(5), .DATA_W(32), .LOC_W(32), .RR_MODE(1'b1))
    u_rr4 (.clock(clk), .reset(rst_n), .flush(fl4), .bus(b4), .rr_ptr_dbg(ptr4));
  cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(1), .TAG_W(5), .DATA_W(32), .LOC_W(32), .RR_MODE(1'b0))
    u_fix (.clock(clk), .reset(rst_n), .flush(fl1), .bus(b1), .rr_ptr_dbg(ptr1));

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  mp;
    logic        fl;
    logic [3:0]  ready;
    logic [1:0]  cval;
    int unsigned l0;
    int unsigned l1;
    logic [1:0]  cmp;
    int unsigned pb;
    int unsigned pa;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    //              valid    mp       fl    ready    cval   l0 l1 cmp    pb pa
    vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 4'b0011, 2'b11, 0, 1, 2'b00, 0, 2};
    vecs[1]  = '{4'b1111, 4'b0000, 1'b0, 4'b1100, 2'b11, 2, 3, 2'b00, 2, 0};
    vecs[2]  = '{4'b1011, 4'b1000, 1'b0, 4'b1001, 2'b11, 3, 0, 2'b01, 0, 1};
    vecs[3]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 2'b01, 2, 0, 2'b00, 1, 3};
    vecs[4]  = '{4'b1001, 4'b0000, 1'b0, 4'b1001, 2'b11, 3, 0, 2'b00, 3, 1};
    vecs[5]  = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 2'b00, 0, 0, 2'b00, 1, 1};
    vecs[6]  = '{4'b0110, 4'b0000, 1'b0, 4'b0110, 2'b11, 1, 2, 2'b00, 1, 3};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 2'b00, 0, 0, 2'b00, 3, 3};
    vecs[8]  = '{4'b1111, 4'b1101, 1'b0, 4'b1001, 2'b11, 3, 0, 2'b11, 3, 1};
    vecs[9]  = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 2'b01, 1, 0, 2'b01, 1, 2};
    vecs[10] = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 2'b01, 1, 0, 2'b00, 2, 2};

    b8.req_valid = '0; b8.req_mispred = '0; b8.req_tag = '0; b8.req_value = '0; b8.req_loc = '0;
    b4.req_valid = '0; b4.req_mispred = '0;
    b1.req_valid = '0; b1.req_mispred = '0;
    for (int i = 0; i < 4; i++) begin
      b4.req_tag[i*5 +: 5]    = 5'(8 + i);
      b4.req_value[i*32 +: 32] = 32'hA000 + 32'(i);
      b4.req_loc[i*32 +: 32]   = 32'((i + 1) * 64);
      b1.req_tag[i*5 +: 5]    = 5'(16 + i);
      b1.req_value[i*32 +: 32] = 32'hB000 + 32'(i);
      b1.req_loc[i*32 +: 32]   = 32'h0;
    end

    // Reset held with every requester valid.
    b8.req_valid = '1;
    #12;
    chk("rst_ready", b8.req_ready, 8'h00);
    chk("rst_cdb_valid", b8.cdb_valid, 2'b00);
    chk("rst_count", b8.cdb_count, 0);
    chk("rst_ptr", ptr8, 0);
    @(posedge clk); #1;
    chk("rst_hold_valid", b8.cdb_valid, 2'b00);

    @(negedge clk);
    rst_n = 1'b1;
    b8.req_valid = 8'b0010_0000;
    b8.req_tag[25 +: 5] = 5'd7;
    b8.req_value[160 +: 32] = 32'hDEAD_0005;
    #1;
    chk("first_ready", b8.req_ready, 8'b0010_0000);
    @(posedge clk); #1;
    chk("first_cdb_valid", b8.cdb_valid, 2'b01);
    chk("first_tag", b8.cdb_tag[0 +: 5], 7);
    chk("first_value", b8.cdb_value[0 +: 32], 32'hDEAD_0005);
    chk("first_count", b8.cdb_count, 1);
    chk("first_ptr", ptr8, 6);
    @(negedge clk);
    b8.req_valid = '0;

    // Table-driven vectors on the 4-requester, 2-lane instance.
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      b4.req_valid   = vecs[v].valid;
      b4.req_mispred = vecs[v].mp;
      fl4            = vecs[v].fl;
      #1;
      chk($sformatf("v%0d_ready", v), b4.req_ready, vecs[v].ready);
      chk($sformatf("v%0d_ptr_before", v), ptr4, vecs[v].pb);
      @(posedge clk); #1;
      chk($sformatf("v%0d_cdb_valid", v), b4.cdb_valid, vecs[v].cval);
      chk($sformatf("v%0d_count", v), b4.cdb_count, $countones(vecs[v].cval));
      if (vecs[v].cval[0]) begin
        chk($sformatf("v%0d_l0_tag", v), b4.cdb_tag[0 +: 5], 8 + vecs[v].l0);
        chk($sformatf("v%0d_l0_value", v), b4.cdb_value[0 +: 32], 32'hA000 + vecs[v].l0);
        chk($sformatf("v%0d_l0_loc", v), b4.cdb_loc[0 +: 32], (vecs[v].l0 + 1) * 64);
        chk($sformatf("v%0d_l0_mp", v), b4.cdb_mispred[0], vecs[v].cmp[0]);
      end
      if (vecs[v].cval[1]) begin
        chk($sformatf("v%0d_l1_tag", v), b4.cdb_tag[5 +: 5], 8 + vecs[v].l1);
        chk($sformatf("v%0d_l1_mp", v), b4.cdb_mispred[1], vecs[v].cmp[1]);
      end
      chk($sformatf("v%0d_ptr_after", v), ptr4, vecs[v].pa);
    end

    // Flush cycle leaves the lanes already on the bus untouched.
    @(negedge clk);
    b4.req_valid = 4'b0011; b4.req_mispred = '0; fl4 = 1'b0;
    @(posedge clk); #1;
    chk("pre_flush_valid", b4.cdb_valid, 2'b11);
    chk("pre_flush_tags", b4.cdb_tag, {5'd9, 5'd8});
    @(negedge clk);
    fl4 = 1'b1;
    #1;
    chk("flush_ready", b4.req_ready, 4'b0000);
    chk("flush_bus_kept", b4.cdb_valid, 2'b11);
    @(posedge clk); #1;
    chk("flush_next_valid", b4.cdb_valid, 2'b00);
    chk("flush_ptr", ptr4, 2);
    @(negedge clk);
    fl4 = 1'b0; b4.req_valid = '0;

    // Fixed priority: highest index wins, req 1 starves, mispred ignored.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      b1.req_valid = 4'b0110;
      #1;
      chk($sformatf("fix%0d_ready", c), b1.req_ready, 4'b0100);
      @(posedge clk); #1;
      chk($sformatf("fix%0d_valid", c), b1.cdb_valid, 1'b1);
      chk($sformatf("fix%0d_tag", c), b1.cdb_tag, 18);
      chk($sformatf("fix%0d_ptr", c), ptr1, 0);
    end
    @(negedge clk);
    b1.req_valid = 4'b1001; b1.req_mispred = 4'b0001;
    #1;
    chk("fix_mp_ready", b1.req_ready, 4'b1000);
    @(posedge clk); #1;
    chk("fix_mp_tag", b1.cdb_tag, 19);
    chk("fix_mp_flag", b1.cdb_mispred, 1'b0);
    @(negedge clk);
    b1.req_valid = '0; b1.req_mispred = '0;

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    b8.req_valid = 8'b0010_0000;
    @(posedge clk); #1;
    chk("mid_valid", b8.cdb_valid, 2'b01);
    chk("mid_ptr", ptr8, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", b8.cdb_valid, 2'b00);
    chk("async_tag", b8.cdb_tag, 0);
    chk("async_count", b8.cdb_count, 0);
    chk("async_ptr", ptr8, 0);
    chk("async_ready", b8.req_ready, 8'h00);
    @(negedge clk);
    b8.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
